uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration. It captures one requester's byte, launches it into the UART TX with a one-cycle data-valid pulse, and waits for the transmitter's done pulse. A watchdog aborts the transfer if the done pulse never arrives. It sits between the command/response logic and the UART TX serializer, in the same clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TX_TIMEOUT_CLKS, 2604, cycles allowed in WAIT_DONE before abort (default is 12 bit times at 217 clks/bit)

Ports:
i_Clock  in  1  system clock
i_Rst_L  in  1  reset, asynchronous assert, active-low
i_Req  in  NUM_REQ  per-requester byte request, level
i_Req_Byte  in  8*NUM_REQ  requester k byte on [8k+7:8k]
i_Req_Lock  in  NUM_REQ  request to keep the grant for the next byte (see Optional Feature)
o_Ack  out  NUM_REQ  one-hot pulse: the byte has been captured
o_Done  out  NUM_REQ  one-hot pulse: that requester's byte has finished transmitting
o_Grant  out  NUM_REQ  one-hot current owner; 0 when idle
o_Busy  out  1  high whenever the state is not IDLE
o_Timeout  out  1  sticky abort flag
o_TX_DV  out  1  one-cycle launch pulse to the UART TX
o_TX_Byte  out  8  byte to the UART TX, held from capture until return to IDLE
i_TX_Active  in  1  the UART TX is shifting
i_TX_Done  in  1  one-cycle pulse from the UART TX at the end of the stop bit

Behaviour:
- Reset (async, i_Rst_L=0):
  - All outputs are 0 and the state is IDLE.
  - The RR pointer is NUM_REQ-1, so requester 0 has first priority.
  - The lock flag and the watchdog counter are cleared.
  - Reset mid-transfer abandons the byte; no o_Done is issued.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - A grant happens when |i_Req=1 and i_TX_Active=0.
  - The winner is the first asserted requester searching upward (with wrap) from pointer+1, unless the lock overrides.
  - At edge E0: o_Grant=onehot(k), o_Ack[k]=1 for one cycle, o_TX_Byte=i_Req_Byte[k], o_Busy=1, then go to LAUNCH.
  - If i_TX_Active=1, stay in IDLE; requests wait.
- LAUNCH: at E1, o_TX_DV=1 for exactly one cycle, the counter is cleared, then go to WAIT_DONE.
- WAIT_DONE:
  - The counter increments every cycle.
  - On i_TX_Done=1: o_Done[k] pulses for one cycle, pointer=k, go to IDLE; o_Grant and o_Busy clear on the same edge.
  - If the counter reaches TX_TIMEOUT_CLKS-1 without done: o_Timeout is set (sticky until reset), no o_Done is issued, pointer=k, the lock is cleared, go to IDLE.
  - If done and timeout occur in the same cycle, done wins and o_Timeout is not set.
- Latency:
  - Request to o_Ack is 1 edge; request to o_TX_DV is 2 edges.
  - Minimum spacing between back-to-back launches is 1 IDLE cycle after done.
- Requester rules:
  - Hold i_Req and the byte stable until o_Ack.
  - The byte may change after o_Ack; it is already captured.
  - Dropping i_Req before o_Ack withdraws the request with no side effect.
- i_TX_Done seen outside WAIT_DONE is ignored.
- Fairness: with all requests continuously asserted and no lock, each requester gets one byte per NUM_REQ grants.

Optional Feature:
Macro: UART_TX_ARB_BURST_LOCK_EN
- Defined:
  - If i_Req_Lock[k]=1 at the capture edge, the lock flag is set for owner k.
  - In the next IDLE, if the lock is set and i_Req[k]=1, k wins regardless of the pointer and the search is skipped.
  - If i_Req[k]=0 in that IDLE cycle, the lock clears and normal RR resumes.
  - A timeout always clears the lock.
- Undefined: i_Req_Lock is ignored and there is no lock flag. The port remains.

Test Plan:
1. Single request: i_Req=4'b0001, byte 8'h37; TX model returns done 2604-10 cycles after DV.
   -> o_Ack[0] at E0, o_TX_DV at E1 with o_TX_Byte=8'h37, o_Done[0] once, o_Timeout=0.
2. Fairness: all four requesting with bytes 8'hA0..8'hA3 held for 8 grants.
   -> grant order 0,1,2,3,0,1,2,3 and o_TX_Byte sequence A0,A1,A2,A3,A0...
3. Timeout: TX model never pulses done.
   -> o_Timeout=1 exactly 2604 cycles after o_TX_DV, no o_Done, next request still granted with o_Timeout still 1.
4. TX busy: i_TX_Active=1 while i_Req=4'b0010.
   -> no o_Ack until one cycle after i_TX_Active falls; done and timeout in the same cycle -> o_Done pulses and o_Timeout=0.
5. Reset in WAIT_DONE: assert i_Rst_L=0 mid-transfer.
   -> all outputs 0 immediately (async), no o_Done; after release, 4'b1111 requests grant 0 first.
6. Burst lock: requester 2 with i_Req_Lock[2]=1 sends 3 bytes while 0 and 1 also request.
   -> defined: grants 2,2,2, then 0.
   -> undefined: grants 2,0,1,2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte requesters, with a done watchdog.
// Define UART_TX_ARB_BURST_LOCK_EN to let an owner keep the grant across consecutive bytes.
module uart_tx_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int TX_TIMEOUT_CLKS = 2604
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_L,
   input  logic [NUM_REQ-1:0]   i_Req,
   input  logic [8*NUM_REQ-1:0] i_Req_Byte,
   input  logic [NUM_REQ-1:0]   i_Req_Lock,
   output logic [NUM_REQ-1:0]   o_Ack,
   output logic [NUM_REQ-1:0]   o_Done,
   output logic [NUM_REQ-1:0]   o_Grant,
   output logic                 o_Busy,
   output logic                 o_Timeout,
   output logic                 o_TX_DV,
   output logic [7:0]           o_TX_Byte,
   input  logic                 i_TX_Active,
   input  logic                 i_TX_Done
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int SUM_W = IDX_W + 1;
   localparam int CNT_W = $clog2(TX_TIMEOUT_CLKS + 1);
   localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_DONE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
   logic [IDX_W-1:0]   r_owner, w_owner_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
   logic [NUM_REQ-1:0] r_done, w_done_nxt;
   logic               r_timeout, w_timeout_nxt;
   logic               r_tx_dv, w_tx_dv_nxt;
   logic [7:0]         r_tx_byte, w_tx_byte_nxt;

   logic               w_busy;
   logic               w_lock_hit;
   logic               w_rr_found;
   logic [IDX_W-1:0]   w_rr_idx;
   logic [SUM_W-1:0]   w_sum;
   logic [IDX_W-1:0]   w_win;
   logic [NUM_REQ-1:0] w_win_onehot;
   logic [7:0]         w_win_byte;

`ifdef UART_TX_ARB_BURST_LOCK_EN
   logic r_lock, w_lock_nxt;
   // The lock always belongs to the previous owner, which is where the pointer rests.
   assign w_lock_hit = r_lock && i_Req[r_ptr];
`else
   logic w_unused_lock;
   assign w_unused_lock = ^i_Req_Lock;
   assign w_lock_hit    = 1'b0;
`endif

   // Search upward from pointer+1 with wrap; the first asserted request wins.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no path infers a latch.
      w_rr_found = 1'b0;
      w_rr_idx   = '0;
      w_sum      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + SUM_W'(i);
         if (w_sum >= SUM_W'(NUM_REQ)) w_sum = w_sum - SUM_W'(NUM_REQ);
         if (!w_rr_found && i_Req[w_sum[IDX_W-1:0]]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = w_sum[IDX_W-1:0];
         end
      end
   end

   assign w_win        = w_lock_hit ? r_ptr : w_rr_idx;
   assign w_win_onehot = NUM_REQ'(1) << w_win;

   always_comb begin
      w_win_byte = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (IDX_W'(k) == w_win) w_win_byte = i_Req_Byte[8*k +: 8];
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_owner_nxt   = r_owner;
      w_cnt_nxt     = r_cnt;
      w_ack_nxt     = '0;
      w_done_nxt    = '0;
      w_timeout_nxt = r_timeout;
      w_tx_dv_nxt   = 1'b0;
      w_tx_byte_nxt = r_tx_byte;
`ifdef UART_TX_ARB_BURST_LOCK_EN
      w_lock_nxt    = r_lock;
`endif
      case (r_state)
         S_IDLE: begin
`ifdef UART_TX_ARB_BURST_LOCK_EN
            if (r_lock && !i_Req[r_ptr]) w_lock_nxt = 1'b0;
`endif
            if ((|i_Req) && !i_TX_Active) begin
               w_state_nxt   = S_LAUNCH;
               w_owner_nxt   = w_win;
               w_ack_nxt     = w_win_onehot;
               w_tx_byte_nxt = w_win_byte;
`ifdef UART_TX_ARB_BURST_LOCK_EN
               w_lock_nxt    = i_Req_Lock[w_win];
`endif
            end
         end
         S_LAUNCH: begin
            w_tx_dv_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            w_cnt_nxt = r_cnt + 1'b1;
            // Done is checked first so a done arriving on the last allowed cycle is not an abort.
            if (i_TX_Done) begin
               w_done_nxt  = NUM_REQ'(1) << r_owner;
               w_ptr_nxt   = r_owner;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout_nxt = 1'b1;
               w_ptr_nxt     = r_owner;
               w_state_nxt   = S_IDLE;
`ifdef UART_TX_ARB_BURST_LOCK_EN
               w_lock_nxt    = 1'b0;
`endif
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_state   <= S_IDLE;
         r_ptr     <= PTR_RST;
         r_owner   <= '0;
         r_cnt     <= '0;
         r_ack     <= '0;
         r_done    <= '0;
         r_timeout <= 1'b0;
         r_tx_dv   <= 1'b0;
         r_tx_byte <= 8'h00;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_owner   <= w_owner_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ack     <= w_ack_nxt;
         r_done    <= w_done_nxt;
         r_timeout <= w_timeout_nxt;
         r_tx_dv   <= w_tx_dv_nxt;
         r_tx_byte <= w_tx_byte_nxt;
      end
   end

`ifdef UART_TX_ARB_BURST_LOCK_EN
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) r_lock <= 1'b0;
      else          r_lock <= w_lock_nxt;
   end
`endif

   assign w_busy    = (r_state != S_IDLE);
   assign o_Busy    = w_busy;
   assign o_Grant   = w_busy ? (NUM_REQ'(1) << r_owner) : '0;
   assign o_Ack     = r_ack;
   assign o_Done    = r_done;
   assign o_Timeout = r_timeout;
   assign o_TX_DV   = r_tx_dv;
   assign o_TX_Byte = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected launches are queued as stimulus is driven and
// compared when o_TX_DV fires; a small UART TX model answers each launch with a done pulse.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 2604;

   typedef struct {
      int         idx;
      logic [7:0] b;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   req_lock;
   logic [8*N-1:0] req_byte;
   logic [N-1:0]   o_ack, o_done, o_grant;
   logic           o_busy, o_timeout, o_tx_dv;
   logic [7:0]     o_tx_byte;
   logic           manual_active, model_active, tx_done, tx_active;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_dv    = 0;
   int   n_done  = 0;
   int   cyc     = 0;
   int   last_dv_cyc, done_cyc, to_cyc, tx_delay;
   bit   to_seen;
   logic [N-1:0] last_grant;
   int   ack_left [N];
   exp_t exp_q [$];

   assign tx_active = manual_active | model_active;

   uart_tx_arbiter #(.NUM_REQ(N), .TX_TIMEOUT_CLKS(TO)) dut (
      .i_Clock     (clk),
      .i_Rst_L     (rst_n),
      .i_Req       (req),
      .i_Req_Byte  (req_byte),
      .i_Req_Lock  (req_lock),
      .o_Ack       (o_ack),
      .o_Done      (o_done),
      .o_Grant     (o_grant),
      .o_Busy      (o_busy),
      .o_Timeout   (o_timeout),
      .o_TX_DV     (o_tx_dv),
      .o_TX_Byte   (o_tx_byte),
      .i_TX_Active (tx_active),
      .i_TX_Done   (tx_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // UART TX model: done is sampled by the arbiter tx_delay edges after the launch edge; 0 = never.
   initial begin
      model_active = 1'b0;
      tx_done      = 1'b0;
      forever begin
         @(negedge clk);
         if (o_tx_dv && tx_delay > 0) begin
            model_active = 1'b1;
            repeat (tx_delay - 1) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done      = 1'b0;
            model_active = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: simulation did not reach its end");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input logic [7:0] b);
      exp_t e;
      e.idx = idx;
      e.b   = b;
      exp_q.push_back(e);
   endtask

   task automatic observe();
      exp_t       e;
      logic [N-1:0] g;
      if (o_tx_dv) begin
         n_dv++;
         last_dv_cyc = cyc;
         last_grant  = o_grant;
         check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = N'(1) << e.idx;
            check("launch_grant", 32'(o_grant), 32'(g));
            check("launch_byte", 32'(o_tx_byte), 32'(e.b));
         end
      end
      if (|o_done) begin
         n_done++;
         done_cyc = cyc;
         check("done_owner", 32'(o_done), 32'(last_grant));
      end
      if (o_timeout && !to_seen) begin
         to_seen = 1'b1;
         to_cyc  = cyc;
      end
      for (int k = 0; k < N; k++) begin
         if (o_ack[k] && ack_left[k] > 0) begin
            ack_left[k]--;
            if (ack_left[k] == 0) req[k] = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      observe();
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int b = budget;
      while (n_done < target && b > 0) begin
         tick();
         b--;
      end
      check(tag, 32'(n_done >= target), 32'd1);
   endtask

   task automatic wait_dv(input int target, input int budget, input string tag);
      int b = budget;
      while (n_dv < target && b > 0) begin
         tick();
         b--;
      end
      check(tag, 32'(n_dv >= target), 32'd1);
   endtask

   task automatic wait_timeout(input int budget, input string tag);
      int b = budget;
      while (!to_seen && b > 0) begin
         tick();
         b--;
      end
      check(tag, 32'(to_seen), 32'd1);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      req           = '0;
      req_lock      = '0;
      manual_active = 1'b0;
      for (int k = 0; k < N; k++) ack_left[k] = 0;
      repeat (3) tick();
      check("reset_outputs",
            32'({o_ack, o_done, o_grant, o_busy, o_timeout, o_tx_dv, o_tx_byte}), 32'd0);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int base;
      int base_dv;
      int b;
      rst_n         = 1'b0;
      req           = '0;
      req_lock      = '0;
      req_byte      = '0;
      manual_active = 1'b0;
      tx_delay      = 0;
      to_seen       = 1'b0;
      last_grant    = '0;
      do_reset();

      // Single request; byte changes after ack but the captured byte must go out.
      req_byte[7:0] = 8'h37;
      tx_delay      = TO - 10;
      ack_left[0]   = 1;
      push(0, 8'h37);
      base = n_done;
      req  = 4'b0001;
      tick();
      check("t1_ack", 32'(o_ack), 32'h1);
      check("t1_grant", 32'(o_grant), 32'h1);
      check("t1_busy", 32'(o_busy), 32'd1);
      req_byte[7:0] = 8'hFF;
      tick();
      check("t1_dv", 32'(o_tx_dv), 32'd1);
      wait_done(base + 1, TO + 20, "t1_done_seen");
      check("t1_done_latency", done_cyc - last_dv_cyc, TO - 10);
      check("t1_no_timeout", 32'(o_timeout), 32'd0);
      repeat (5) tick();
      check("t1_single_done", n_done, base + 1);
      check("t1_idle", 32'(o_busy), 32'd0);

      // Fairness from reset: all four requesting, two bytes each.
      do_reset();
      req_byte = 32'hA3A2A1A0;
      tx_delay = 20;
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N; k++) push(k, 8'hA0 + 8'(k));
      for (int k = 0; k < N; k++) ack_left[k] = 2;
      base = n_done;
      req  = '1;
      wait_done(base + 8, 400, "t2_done_count");
      check("t2_drained", exp_q.size(), 0);

      // TX busy holds off grants; a withdrawn request leaves no trace; done ties with timeout.
      tick();
      manual_active  = 1'b1;
      req_byte[15:8] = 8'hB4;
      req_byte[7:0]  = 8'h5A;
      tx_delay       = TO;
      push(1, 8'hB4);
      ack_left[1] = 1;
      req = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_held_off", 32'(o_ack), 32'd0);
      end
      req[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t4_held_off", 32'(o_ack), 32'd0);
      end
      manual_active = 1'b0;
      tick();
      check("t4_ack_after_active", 32'(o_ack), 32'h2);
      base = n_done;
      wait_done(base + 1, TO + 20, "t4_done_seen");
      check("t4_tie_latency", done_cyc - last_dv_cyc, TO);
      check("t4_tie_no_timeout", 32'(o_timeout), 32'd0);
      tick();
      check("t4_tie_no_timeout_after", 32'(o_timeout), 32'd0);

      // Watchdog abort, then a fresh request is still served with the flag sticky.
      tick();
      tx_delay        = 0;
      to_seen         = 1'b0;
      req_byte[23:16] = 8'hC5;
      push(2, 8'hC5);
      ack_left[2] = 1;
      base = n_done;
      req  = 4'b0100;
      wait_timeout(TO + 20, "t3_timeout_seen");
      check("t3_timeout_latency", to_cyc - last_dv_cyc, TO);
      check("t3_no_done", n_done, base);
      check("t3_idle_after_abort", 32'(o_busy), 32'd0);
      req_byte[31:24] = 8'hD6;
      push(3, 8'hD6);
      ack_left[3] = 1;
      tx_delay    = 5;
      req         = 4'b1000;
      tick();
      check("t3_regrant_ack", 32'(o_ack), 32'h8);
      wait_done(base + 1, 50, "t3_regrant_done");
      check("t3_timeout_sticky", 32'(o_timeout), 32'd1);

      // Reset during WAIT_DONE: immediate clear, late TX done ignored, priority back to 0.
      tick();
      req_byte[7:0] = 8'h11;
      push(0, 8'h11);
      ack_left[0] = 1;
      tx_delay    = 100;
      base_dv     = n_dv;
      req         = 4'b0001;
      wait_dv(base_dv + 1, 10, "t5_launch");
      repeat (10) tick();
      base = n_done;
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_clear",
            32'({o_ack, o_done, o_grant, o_busy, o_timeout, o_tx_dv, o_tx_byte}), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      b = 200;
      while (model_active && b > 0) begin
         tick();
         b--;
      end
      check("t5_model_finished", 32'(model_active), 32'd0);
      repeat (2) tick();
      check("t5_no_done", n_done, base);
      req_byte = 32'h24232221;
      push(0, 8'h21);
      tx_delay = 5;
      req      = 4'b1111;
      tick();
      check("t5_first_after_reset", 32'(o_ack), 32'h1);
      req = '0;
      wait_done(base + 1, 50, "t5_post_reset_done");

      // Burst lock: prime the pointer to 1 so requester 2 wins first.
      tick();
      req_byte[15:8] = 8'h31;
      push(1, 8'h31);
      ack_left[1] = 1;
      tx_delay    = 5;
      base        = n_done;
      req         = 4'b0010;
      wait_done(base + 1, 50, "t6_prime");
      req_byte    = 32'h00E2E1E0;
      req_lock    = 4'b0100;
      ack_left[0] = 1;
      ack_left[1] = 1;
      ack_left[2] = 3;
`ifdef UART_TX_ARB_BURST_LOCK_EN
      push(2, 8'hE2);
      push(2, 8'hE2);
      push(2, 8'hE2);
      push(0, 8'hE0);
      push(1, 8'hE1);
`else
      push(2, 8'hE2);
      push(0, 8'hE0);
      push(1, 8'hE1);
      push(2, 8'hE2);
      push(2, 8'hE2);
`endif
      base = n_done;
      req  = 4'b0111;
      wait_done(base + 5, 300, "t6_done_count");
      check("t6_drained", exp_q.size(), 0);
      check("t6_idle", 32'(o_busy), 32'd0);
      req_lock = '0;

      repeat (3) tick();
      check("sb_final_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
